pkt_burst_reader: RTL and testbench

Parametrised successor to the single-burst packet read controller.
- Fetches one captured packet from HPS/SDRAM memory over an Avalon-MM host port. The packet is the byte range [pkt_begin, pkt_end).
- Splits the packet into bursts of at most MAX_BURST words and pushes every returned word into the capture FIFO.
- Honours waitrequest, readdatavalid and FIFO back-pressure, and supports abort. Sits between the control register block and the pcap FIFO.

---
 rtl/pkt_rd_pkg.sv | 23 ++
 rtl/pkt_rd_beat_sink.sv | 47 ++++
 rtl/pkt_burst_reader.sv | 148 ++++++++++++++
 tb/tb_pkt_burst_reader.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_rd_pkg.sv
// Shared state encoding and sizing helpers for the packet burst reader.
package pkt_rd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DATA,
    DONE,
    DONE_ABORT
  } rd_state_e;

  // Bytes carried by one data word; used to size localparams in the users.
  function automatic int unsigned bytes_per_word(input int unsigned data_w);
    return data_w / 8;
  endfunction

  // Words to request in the next burst: the tail of the packet or a full burst.
  function automatic int unsigned burst_words(input int unsigned remaining,
                                              input int unsigned max_burst);
    return (remaining < max_burst) ? remaining : max_burst;
  endfunction

endpackage

// File: rtl/pkt_rd_beat_sink.sv
// Return-data stage: registers each accepted read beat toward the capture
// FIFO and counts down the beats still owed by the outstanding burst.
module pkt_rd_beat_sink #(
  parameter int DATA_W  = 32,
  parameter int BURST_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               load,
  input  logic [BURST_W-1:0] load_cnt,
  input  logic               readdatavalid,
  input  logic [DATA_W-1:0]  readdata,
  output logic [DATA_W-1:0]  fifo_data,
  output logic               fifo_wr,
  output logic               last_beat
);

  localparam int STAGES = 1;

  logic [STAGES:0]    vld_pipe;
  logic [STAGES:1]    vld_q;
  logic [BURST_W-1:0] beats_left;

  // Stage 0 is the raw beat, qualified so data arriving outside a burst is dropped.
  always_comb begin
    vld_pipe = {vld_q, en & readdatavalid};
  end

  assign last_beat = vld_pipe[0] && (beats_left == BURST_W'(1));
  assign fifo_wr   = vld_pipe[STAGES];

  // Beat register plus per-burst countdown, reloaded when a command is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q      <= '0;
      fifo_data  <= '0;
      beats_left <= '0;
    end else begin
      vld_q <= vld_pipe[STAGES-1:0];
      if (vld_pipe[0]) fifo_data <= readdata;
      if (load) beats_left <= load_cnt;
      else if (vld_pipe[0] && (beats_left != '0)) beats_left <= beats_left - 1'b1;
    end
  end

endmodule

// File: rtl/pkt_burst_reader.sv
// Packet read controller: walks [pkt_begin, pkt_end) in bursts of up to
// MAX_BURST words over Avalon-MM and streams every returned word to the FIFO.
module pkt_burst_reader
  import pkt_rd_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int BURST_W   = 5,
  parameter int LEN_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [ADDR_W-1:0]  pkt_begin,
  input  logic [ADDR_W-1:0]  pkt_end,
  output logic               busy,
  output logic               done,
  output logic               err,
  input  logic               fifo_almost_full,
  output logic [DATA_W-1:0]  fifo_data,
  output logic               fifo_wr,
  output logic [ADDR_W-1:0]  address,
  output logic               read,
  output logic [BURST_W-1:0] burstcount,
  input  logic               waitrequest,
  input  logic [DATA_W-1:0]  readdata,
  input  logic               readdatavalid
);

  localparam int BYTES = bytes_per_word(DATA_W);
  localparam int OFS_W = $clog2(BYTES);

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [LEN_W-1:0]  remaining_q;
  logic              abort_pend_q;
  logic              cmd_hold_q;
  logic              err_q;
  logic [LEN_W-1:0]  len_words;
  logic              range_bad;
  logic              cmd_acc;
  logic              last_beat;
  logic              sink_en;

  // Request decode: word length rounded up, and validity of the sampled range.
  always_comb begin
    len_words = LEN_W'(({1'b0, pkt_end - pkt_begin} + (ADDR_W+1)'(BYTES - 1)) >> OFS_W);
    range_bad = ((pkt_begin & ADDR_W'(BYTES - 1)) != '0) || (pkt_end < pkt_begin);
  end

  // Command fields come straight from the walk registers, so they cannot
  // move while the fabric stalls the request.
  assign address    = cur_addr_q;
  assign burstcount = BURST_W'(burst_words(32'(remaining_q), MAX_BURST));
  assign cmd_acc    = read && !waitrequest;
  assign err        = err_q;
  assign sink_en    = (state_q == WAIT_DATA);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a pending or coincident abort ends the walk at a burst edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:
        if (start && !range_bad) state_d = (len_words == '0) ? DONE : ISSUE;
      ISSUE:
        if (abort)        state_d = DONE_ABORT;
        else if (cmd_acc) state_d = WAIT_DATA;
      WAIT_DATA:
        if (last_beat) begin
          if (remaining_q == '0)           state_d = DONE;
          else if (abort_pend_q || abort)  state_d = DONE_ABORT;
          else                             state_d = ISSUE;
        end
      DONE, DONE_ABORT:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  // Outputs; once a stalled command is on the bus it stays up despite back-pressure.
  always_comb begin
    read = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ISSUE: begin
        busy = 1'b1;
        read = !abort && (cmd_hold_q || !fifo_almost_full);
      end
      WAIT_DATA: busy = 1'b1;
      DONE:      done = 1'b1;
      default:   ;
    endcase
  end

  // Walk registers: address/word budget, stall hold, abort latch and error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_addr_q   <= '0;
      remaining_q  <= '0;
      abort_pend_q <= 1'b0;
      cmd_hold_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      err_q      <= (state_q == IDLE) && start && range_bad;
      cmd_hold_q <= read && waitrequest;
      if (state_q == IDLE) begin
        abort_pend_q <= 1'b0;
        if (start && !range_bad) begin
          cur_addr_q  <= pkt_begin;
          remaining_q <= len_words;
        end
      end else begin
        if (cmd_acc) begin
          cur_addr_q  <= cur_addr_q + (ADDR_W'(burstcount) << OFS_W);
          remaining_q <= remaining_q - LEN_W'(burstcount);
        end
        if ((state_q == WAIT_DATA) && abort) abort_pend_q <= 1'b1;
      end
    end
  end

  pkt_rd_beat_sink #(
    .DATA_W  (DATA_W),
    .BURST_W (BURST_W)
  ) u_sink (
    .clk           (clk),
    .reset         (reset),
    .en            (sink_en),
    .load          (cmd_acc),
    .load_cnt      (burstcount),
    .readdatavalid (readdatavalid),
    .readdata      (readdata),
    .fifo_data     (fifo_data),
    .fifo_wr       (fifo_wr),
    .last_beat     (last_beat)
  );

endmodule

// File: tb/tb_pkt_burst_reader.sv
// Bench for pkt_burst_reader: Avalon slave model with a word-per-address
// memory image, scoreboard of expected commands and FIFO words, table of
// directed packets, hand sequences for abort/reset/stall, then random packets.
module tb_pkt_burst_reader;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 16;
  localparam int BW = 5;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] pkt_begin = '0;
  logic [AW-1:0] pkt_end = '0;
  logic          fifo_almost_full = 1'b0;
  logic          waitrequest = 1'b0;
  logic [DW-1:0] readdata = '0;
  logic          readdatavalid = 1'b0;
  logic          busy, done, err, fifo_wr, read;
  logic [DW-1:0] fifo_data;
  logic [AW-1:0] address;
  logic [BW-1:0] burstcount;

  pkt_burst_reader #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .BURST_W(BW), .LEN_W(LW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pkt_begin(pkt_begin), .pkt_end(pkt_end),
    .busy(busy), .done(done), .err(err),
    .fifo_almost_full(fifo_almost_full), .fifo_data(fifo_data), .fifo_wr(fifo_wr),
    .address(address), .read(read), .burstcount(burstcount),
    .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // scoreboard
  logic [31:0] exp_words[$];
  logic [31:0] exp_cmd_addr[$];
  int          exp_cmd_len[$];
  int done_cnt = 0, err_cnt = 0, wr_cnt = 0, beats_driven = 0;

  // slave model state
  logic [31:0] sl_addr = '0;
  int          sl_left = 0, sl_idx = 0;
  logic        last_legit = 1'b0;
  logic [31:0] last_data = '0;
  logic        prev_held = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [BW-1:0] prev_bc = '0;
  int wr_pct = 0, rdv_pct = 100, wr_force = 0, stray = 0;
  bit rand_af = 1'b0;

  typedef struct {
    logic [31:0] b;
    logic [31:0] e;
    bit          exp_err;
    bit          exp_done;
    int          words;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  // memory image: odd multiplier makes every word address map to a distinct value
  function automatic logic [31:0] memw(input logic [31:0] a);
    return a * 32'h9E3779B1 + 32'h01234567;
  endfunction

  // Expected traffic straight from the packet rules: ceil-div length, 16-word chunks.
  task automatic model_load(input logic [31:0] b, input logic [31:0] e, output int words);
    longint unsigned nbytes, nw, left, n;
    logic [31:0] a;
    exp_words.delete(); exp_cmd_addr.delete(); exp_cmd_len.delete();
    words = 0;
    if ((b % 4) != 0 || e < b) return;
    nbytes = 64'(e) - 64'(b);
    nw = ((nbytes + 3) / 4) % 65536;
    words = int'(nw);
    for (int i = 0; i < words; i++) exp_words.push_back(memw(b + 32'(i * 4)));
    a = b; left = nw;
    while (left > 0) begin
      n = (left > MB) ? MB : left;
      exp_cmd_addr.push_back(a);
      exp_cmd_len.push_back(int'(n));
      a = a + 32'(n * 4);
      left = left - n;
    end
  endtask

  task automatic flush_slave();
    sl_left = 0; sl_idx = 0; last_legit = 1'b0; prev_held = 1'b0;
    exp_words.delete(); exp_cmd_addr.delete(); exp_cmd_len.delete();
  endtask

  // One clock: drive slave inputs, check the command bus, clock, check FIFO side.
  task automatic tick();
    logic [31:0] ca;
    int cl;
    #1;
    readdatavalid = 1'b0;
    last_legit = 1'b0;
    if (sl_left > 0 && ($urandom_range(99) < rdv_pct)) begin
      readdatavalid = 1'b1;
      readdata = memw(sl_addr + 32'(sl_idx * 4));
      last_legit = 1'b1; last_data = readdata;
      sl_idx++; sl_left--; beats_driven++;
    end else if (stray > 0) begin
      readdatavalid = 1'b1;
      readdata = $urandom;
      stray--;
    end
    if (wr_force > 0) begin
      waitrequest = 1'b1; wr_force--;
    end else begin
      waitrequest = ($urandom_range(99) < wr_pct);
    end
    #1;
    chk("read_blocked_by_af", read && fifo_almost_full && !prev_held, 0);
    chk("read_held_in_stall", prev_held && !abort && !read, 0);
    chk("one_burst_outstanding", read && (sl_left > 0), 0);
    if (prev_held && read) begin
      chk("addr_stable", address, prev_addr);
      chk("bc_stable", burstcount, prev_bc);
    end
    if (read && !waitrequest) begin
      chk("cmd_expected", exp_cmd_addr.size() > 0, 1);
      if (exp_cmd_addr.size() > 0) begin
        ca = exp_cmd_addr.pop_front();
        cl = exp_cmd_len.pop_front();
        chk("cmd_addr", address, ca);
        chk("cmd_burstcount", burstcount, cl);
      end
      sl_addr = address; sl_left = int'(burstcount); sl_idx = 0;
    end
    prev_held = read && waitrequest;
    prev_addr = address;
    prev_bc = burstcount;
    @(posedge clk);
    @(negedge clk);
    chk("fifo_wr_timing", fifo_wr, last_legit);
    if (fifo_wr) begin
      wr_cnt++;
      chk("fifo_data_raw", fifo_data, last_data);
      chk("fifo_word_expected", exp_words.size() > 0, 1);
      if (exp_words.size() > 0) chk("fifo_data_model", fifo_data, exp_words.pop_front());
    end
    if (done) done_cnt++;
    if (err) err_cnt++;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_read"}, read, 0);
    chk({tag, "_fifo_wr"}, fifo_wr, 0);
    chk({tag, "_address"}, address, 0);
    chk({tag, "_burstcount"}, burstcount, 0);
    chk({tag, "_fifo_data"}, fifo_data, 0);
  endtask

  task automatic wait_beats(input int n);
    int k = 0;
    while (beats_driven < n && k < 300) begin tick(); k++; end
    chk("beat_wait_in_time", beats_driven >= n, 1);
  endtask

  task automatic finish_pkt(input string tag, input int exp_done, input int exp_err, input int words);
    int n = 0;
    while (busy && n < 3000) begin
      tick(); n++;
      if (rand_af) fifo_almost_full = ($urandom_range(3) == 0);
    end
    chk({tag, "_busy_falls_in_time"}, busy, 0);
    fifo_almost_full = 1'b0;
    tick(); tick();
    chk({tag, "_done_cycles"}, done_cnt, exp_done);
    chk({tag, "_err_cycles"}, err_cnt, exp_err);
    chk({tag, "_words_written"}, wr_cnt, words);
    chk({tag, "_words_left"}, exp_words.size(), 0);
    chk({tag, "_cmds_left"}, exp_cmd_addr.size(), 0);
  endtask

  task automatic begin_pkt(input logic [31:0] b, input logic [31:0] e);
    done_cnt = 0; err_cnt = 0; wr_cnt = 0; beats_driven = 0;
    pkt_begin = b; pkt_end = e; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_pkt(input string tag, input logic [31:0] b, input logic [31:0] e,
                         input bit exp_err, input bit exp_done, input int words);
    int mw;
    model_load(b, e, mw);
    chk({tag, "_model_len"}, mw, words);
    begin_pkt(b, e);
    chk({tag, "_err_pulse"}, err, exp_err);
    chk({tag, "_busy_rise"}, busy, !exp_err && words > 0);
    chk({tag, "_zero_len_done"}, done, exp_done && words == 0);
    finish_pkt(tag, exp_done, exp_err, words);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w;
    logic [31:0] b, e;
    bit bad;

    repeat (3) tick();
    check_reset_outputs("por");
    reset = 1'b1;
    tick();

    vecs[0] = '{32'h0000_1000, 32'h0000_1040, 1'b0, 1'b1, 16};
    vecs[1] = '{32'h0000_2000, 32'h0000_2052, 1'b0, 1'b1, 21};
    vecs[2] = '{32'h0000_1002, 32'h0000_1040, 1'b1, 1'b0, 0};
    vecs[3] = '{32'h0000_3000, 32'h0000_3000, 1'b0, 1'b1, 0};
    vecs[4] = '{32'h0000_5000, 32'h0000_4FFC, 1'b1, 1'b0, 0};
    vecs[5] = '{32'h0000_4000, 32'h0000_4001, 1'b0, 1'b1, 1};
    vecs[6] = '{32'hFFFF_FFC0, 32'hFFFF_FFFF, 1'b0, 1'b1, 16};
    vecs[7] = '{32'h0000_6000, 32'h0000_6101, 1'b0, 1'b1, 65};
    for (int i = 0; i < 8; i++) begin
      wr_pct = (i < 2) ? 0 : 30;
      rdv_pct = (i < 2) ? 100 : 70;
      run_pkt($sformatf("vec%0d", i), vecs[i].b, vecs[i].e, vecs[i].exp_err,
              vecs[i].exp_done, vecs[i].words);
    end

    // back-pressure then a stalled command
    wr_pct = 0; rdv_pct = 100;
    model_load(32'h7000, 32'h7040, w);
    fifo_almost_full = 1'b1;
    begin_pkt(32'h7000, 32'h7040);
    for (int i = 0; i < 5; i++) begin
      chk("af_read_low", read, 0);
      tick();
    end
    fifo_almost_full = 1'b0;
    wr_force = 3;
    #1;
    chk("read_after_af", read, 1);
    chk("af_addr", address, 32'h7000);
    chk("af_bc", burstcount, 16);
    finish_pkt("stall", 1, 0, 16);

    // abort during the first burst of a 40-word packet
    rdv_pct = 80;
    model_load(32'h8000, 32'h80A0, w);
    chk("abort_model_len", w, 40);
    while (exp_words.size() > 16) void'(exp_words.pop_back());
    while (exp_cmd_addr.size() > 1) begin
      void'(exp_cmd_addr.pop_back()); void'(exp_cmd_len.pop_back());
    end
    begin_pkt(32'h8000, 32'h80A0);
    wait_beats(4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    finish_pkt("abort_wait", 0, 0, 16);

    // abort while the request is still held back by the FIFO
    flush_slave();
    fifo_almost_full = 1'b1;
    begin_pkt(32'h5000, 32'h5040);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_issue_busy", busy, 0);
    finish_pkt("abort_issue", 0, 0, 0);

    // start while busy is ignored
    rdv_pct = 100;
    model_load(32'h2000, 32'h2052, w);
    begin_pkt(32'h2000, 32'h2052);
    repeat (3) tick();
    pkt_begin = 32'h9000; pkt_end = 32'h9100; start = 1'b1;
    tick();
    start = 1'b0;
    finish_pkt("start_busy", 1, 0, 21);

    // reset mid-burst, then stray data in IDLE
    model_load(32'hA000, 32'hA0A0, w);
    begin_pkt(32'hA000, 32'hA0A0);
    wait_beats(3);
    reset = 1'b0;
    flush_slave();
    tick();
    check_reset_outputs("midrst");
    reset = 1'b1;
    wr_cnt = 0;
    stray = 3;
    repeat (5) tick();
    chk("stray_no_fifo_wr", wr_cnt, 0);
    chk("stray_busy", busy, 0);

    // random packets
    rand_af = 1'b1; wr_pct = 25; rdv_pct = 60;
    for (int i = 0; i < 15; i++) begin
      b = 32'($urandom_range(0, 32'h3FFF)) << 4;
      if ($urandom_range(5) == 0) b = b + 32'($urandom_range(1, 3));
      e = b + 32'($urandom_range(0, 300));
      if ($urandom_range(7) == 0) e = b - 32'($urandom_range(1, 40));
      bad = ((b % 4) != 0) || (e < b);
      w = bad ? 0 : int'((64'(e) - 64'(b) + 3) / 4);
      run_pkt($sformatf("rnd%0d", i), b, e, bad, !bad, w);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
